mem_wb_lane_merge_reg: RTL and testbench

- Parametrised MEM/WB writeback-data stage that merges per-lane EX/MEM data with load results and registers the result.
- Generalises the 2x8-bit combinational select to LANES x DATA_W.
- Tolerates late load data through a wait state with ld_valid/ld_ack.
- Provides a valid/ready output handshake, synchronous flush and a sticky load-timeout error.

---
 rtl/mem_wb_lane_merge_reg_pkg.sv | 16 +
 rtl/mem_wb_lane_merge_reg_if.sv | 31 +++
 rtl/mem_wb_lane_merge_reg_lane_merge.sv | 19 +
 rtl/mem_wb_lane_merge_reg.sv | 156 +++++++++++++++
 tb/tb_mem_wb_lane_merge_reg.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_lane_merge_reg_pkg.sv
// Shared types and helpers for the MEM/WB lane-merge writeback stage.
package mem_wb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 2;

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/mem_wb_lane_merge_reg_if.sv
// Handshake and data bundle between EX/MEM, the load unit and WB.
interface mem_wb_lane_merge_reg_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES-1:0]          sel;
  logic [LANES*DATA_W-1:0]   mem_data;
  logic                      ld_valid;
  logic [LANES*DATA_W-1:0]   ld_res;
  logic                      ld_ack;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [LANES-1:0]          out_ld_sel;
  logic                      timeout_err;

  modport master (
    output flush, in_valid, sel, mem_data, ld_valid, ld_res, out_ready,
    input  in_ready, ld_ack, out_valid, out_data, out_ld_sel, timeout_err
  );

  modport slave (
    input  flush, in_valid, sel, mem_data, ld_valid, ld_res, out_ready,
    output in_ready, ld_ack, out_valid, out_data, out_ld_sel, timeout_err
  );
endinterface

// File: rtl/mem_wb_lane_merge_reg_lane_merge.sv
// Per-lane select between base data and load result; pure wiring, no arithmetic.
module lane_merge
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic [LANES*DATA_W-1:0] base_i,
  input  logic [LANES*DATA_W-1:0] ld_i,
  input  logic [LANES-1:0]        sel_i,
  output logic [LANES*DATA_W-1:0] merged_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, DATA_W);
    assign merged_o[LSB +: DATA_W] = sel_i[i] ? ld_i[LSB +: DATA_W] : base_i[LSB +: DATA_W];
  end

endmodule

// File: rtl/mem_wb_lane_merge_reg.sv
// MEM/WB writeback register: merges EX/MEM lanes with (possibly late) load data.
// state   | meaning
// IDLE    | ready to accept an EX/MEM entry when the output slot frees
// WAIT_LD | holding a load-dependent entry until ld_valid or timeout
module mem_wb_lane_merge_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int TIMEOUT = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  mem_wb_lane_merge_reg_if.slave  bus
);

  localparam int W     = LANES * DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      hold_data_q, hold_data_d;
  logic [LANES-1:0]  hold_sel_q, hold_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [LANES-1:0]  out_ld_sel_q, out_ld_sel_d;
  logic              timeout_err_q, timeout_err_d;

  logic              slot_free;
  logic              in_ready;
  logic              ld_ack;
  logic              accept;
  logic              direct_fire;
  logic              wait_fire;
  logic [W-1:0]      direct_data;
  logic [W-1:0]      wait_data;

  lane_merge #(.DATA_W(DATA_W), .LANES(LANES)) u_merge_direct (
    .base_i   (bus.mem_data),
    .ld_i     (bus.ld_res),
    .sel_i    (bus.sel),
    .merged_o (direct_data)
  );

  lane_merge #(.DATA_W(DATA_W), .LANES(LANES)) u_merge_wait (
    .base_i   (hold_data_q),
    .ld_i     (bus.ld_res),
    .sel_i    (hold_sel_q),
    .merged_o (wait_data)
  );

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_data_q   <= '0;
      hold_sel_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_ld_sel_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_data_q   <= hold_data_d;
      hold_sel_q    <= hold_sel_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ld_sel_q  <= out_ld_sel_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_data_d   = hold_data_q;
    hold_sel_d    = hold_sel_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ld_sel_d  = out_ld_sel_q;
    timeout_err_d = timeout_err_q;
    if (bus.flush) begin
      // out_data is intentionally left as-is; only validity is dropped
      out_valid_d   = 1'b0;
      state_d       = IDLE;
      cnt_d         = '0;
      timeout_err_d = 1'b0;
    end else begin
      if (direct_fire) begin
        out_valid_d  = 1'b1;
        out_data_d   = direct_data;
        out_ld_sel_d = bus.sel;
      end else if (wait_fire) begin
        out_valid_d  = 1'b1;
        out_data_d   = wait_data;
        out_ld_sel_d = hold_sel_q;
      end else if (bus.out_ready) begin
        out_valid_d  = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept && !direct_fire) begin
            hold_data_d = bus.mem_data;
            hold_sel_d  = bus.sel;
            cnt_d       = '0;
            state_d     = WAIT_LD;
          end
        end
        WAIT_LD: begin
          if (wait_fire) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs are combinational and forced low during reset or flush
  always_comb begin
    in_ready    = 1'b0;
    direct_fire = 1'b0;
    wait_fire   = 1'b0;
    if (reset_n && !bus.flush) begin
      case (state_q)
        IDLE: begin
          in_ready    = slot_free;
          direct_fire = bus.in_valid && slot_free && ((bus.sel == '0) || bus.ld_valid);
        end
        WAIT_LD: wait_fire = bus.ld_valid && slot_free;
        default: ;
      endcase
    end
    ld_ack = (direct_fire && (bus.sel != '0)) || wait_fire;
  end

  assign bus.in_ready    = in_ready;
  assign bus.ld_ack      = ld_ack;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_ld_sel  = out_ld_sel_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_wb_lane_merge_reg.sv
// Directed bench for mem_wb_lane_merge_reg with a cycle-level reference model.
module tb_mem_wb_lane_merge_reg;
  localparam int DW = 8;
  localparam int NL = 2;
  localparam int TO = 4;
  localparam int W  = DW * NL;

  logic clock;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_wb_lane_merge_reg_if #(.DATA_W(DW), .LANES(NL)) bus ();

  mem_wb_lane_merge_reg #(.DATA_W(DW), .LANES(NL), .TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending entry, one output slot, a wait-cycle tally
  logic [W-1:0]  m_data = '0;
  logic [NL-1:0] m_sel  = '0;
  logic [W-1:0]  m_hold = '0;
  logic [NL-1:0] m_hsel = '0;
  bit            m_ov = 0, m_err = 0, m_waiting = 0;
  int            m_waited = 0;

  function automatic logic [W-1:0] merge_ref(input logic [W-1:0] base, input logic [W-1:0] ld,
                                             input logic [NL-1:0] s);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = s[b / DW] ? ld[b] : base[b];
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    bit            free, fire;
    logic [W-1:0]  nd;
    logic [NL-1:0] ns;
    if (!reset_n) begin
      m_data = '0; m_sel = '0; m_hold = '0; m_hsel = '0;
      m_ov = 0; m_err = 0; m_waiting = 0; m_waited = 0;
    end else if (bus.flush) begin
      m_ov = 0; m_err = 0; m_waiting = 0; m_waited = 0;
    end else begin
      free = !m_ov || bus.out_ready;
      fire = 0; nd = '0; ns = '0;
      if (m_waiting) begin
        m_waited++;
        if (bus.ld_valid && free) begin
          fire = 1; nd = merge_ref(m_hold, bus.ld_res, m_hsel); ns = m_hsel; m_waiting = 0;
        end else if (m_waited == TO) begin
          m_err = 1; m_waiting = 0;
        end
      end else if (bus.in_valid && free) begin
        if (bus.sel == '0 || bus.ld_valid) begin
          fire = 1; nd = merge_ref(bus.mem_data, bus.ld_res, bus.sel); ns = bus.sel;
        end else begin
          m_waiting = 1; m_waited = 0; m_hold = bus.mem_data; m_hsel = bus.sel;
        end
      end
      if (fire) begin
        m_ov = 1; m_data = nd; m_sel = ns;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
    end
  end

  always @(negedge clock) begin : cmp
    bit free, exp_ir, exp_ack;
    free    = !m_ov || bus.out_ready;
    exp_ir  = reset_n && !bus.flush && !m_waiting && free;
    exp_ack = reset_n && !bus.flush && bus.ld_valid && free &&
              (m_waiting || (bus.in_valid && exp_ir && bus.sel != '0));
    chk("cyc_out_valid",   32'(bus.out_valid),   32'(m_ov));
    chk("cyc_out_data",    32'(bus.out_data),    32'(m_data));
    chk("cyc_out_ld_sel",  32'(bus.out_ld_sel),  32'(m_sel));
    chk("cyc_timeout_err", 32'(bus.timeout_err), 32'(m_err));
    chk("cyc_in_ready",    32'(bus.in_ready),    32'(exp_ir));
    chk("cyc_ld_ack",      32'(bus.ld_ack),      32'(exp_ack));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.flush = 0; bus.in_valid = 0; bus.sel = '0; bus.mem_data = '0;
    bus.ld_valid = 0; bus.ld_res = '0; bus.out_ready = 1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_timeout",   32'(bus.timeout_err), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    tick();
    reset_n = 1'b1;

    // sel=0: plain pass-through, load bus ignored
    bus.in_valid = 1; bus.sel = 2'b00; bus.mem_data = 16'hA55A; bus.ld_valid = 1; bus.ld_res = 16'hFFFF;
    #1 chk("t1_in_ready", 32'(bus.in_ready), 1);
    chk("t1_ld_ack", 32'(bus.ld_ack), 0);
    tick();
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_out_data",  32'(bus.out_data), 32'h A55A);

    // sel=01 with load present in the same cycle
    bus.sel = 2'b01; bus.mem_data = 16'h1234; bus.ld_res = 16'hABCD;
    #1 chk("t2_ld_ack", 32'(bus.ld_ack), 1);
    tick();
    chk("t2_out_data",   32'(bus.out_data), 32'h12CD);
    chk("t2_out_ld_sel", 32'(bus.out_ld_sel), 2'b01);

    // sel=11, load arrives after three low cycles
    bus.sel = 2'b11; bus.mem_data = 16'h1111; bus.ld_valid = 0;
    tick();
    bus.sel = 2'b00; bus.mem_data = 16'h5555;
    #1 chk("t3_in_ready_w0", 32'(bus.in_ready), 0);
    chk("t3_out_valid_w0", 32'(bus.out_valid), 0);
    tick();
    bus.in_valid = 0;
    #1 chk("t3_in_ready_w1", 32'(bus.in_ready), 0);
    tick();
    bus.ld_valid = 1; bus.ld_res = 16'hBEEF;
    #1 chk("t3_ld_ack", 32'(bus.ld_ack), 1);
    tick();
    bus.ld_valid = 0;
    chk("t3_out_data",  32'(bus.out_data), 32'hBEEF);
    chk("t3_out_valid", 32'(bus.out_valid), 1);

    // backpressure then drain + accept in one cycle
    bus.out_ready = 0; bus.in_valid = 1; bus.sel = 2'b00; bus.mem_data = 16'h7E57;
    #1 chk("t4_in_ready_bp", 32'(bus.in_ready), 0);
    tick();
    chk("t4_hold_data", 32'(bus.out_data), 32'hBEEF);
    bus.out_ready = 1;
    #1 chk("t4_in_ready_drain", 32'(bus.in_ready), 1);
    tick();
    chk("t4_b2b_data",  32'(bus.out_data), 32'h7E57);
    chk("t4_b2b_valid", 32'(bus.out_valid), 1);
    bus.in_valid = 0;
    tick();
    chk("t4_drained", 32'(bus.out_valid), 0);

    // load arrives on the very last allowed wait cycle
    bus.in_valid = 1; bus.sel = 2'b01; bus.mem_data = 16'h0F0F;
    tick();
    bus.in_valid = 0;
    tick(); tick(); tick();
    bus.ld_valid = 1; bus.ld_res = 16'h00AA;
    #1 chk("t5_ld_ack_last", 32'(bus.ld_ack), 1);
    tick();
    bus.ld_valid = 0;
    chk("t5_out_data", 32'(bus.out_data), 32'h0FAA);
    chk("t5_no_err",   32'(bus.timeout_err), 0);

    // timeout after TO wait cycles, then flush clears it
    bus.in_valid = 1; bus.sel = 2'b10; bus.mem_data = 16'hC3C3;
    tick();
    bus.in_valid = 0;
    tick(); tick(); tick();
    chk("t6_err_before", 32'(bus.timeout_err), 0);
    tick();
    chk("t6_err_set",   32'(bus.timeout_err), 1);
    chk("t6_out_valid", 32'(bus.out_valid), 0);
    chk("t6_in_ready",  32'(bus.in_ready), 1);
    bus.flush = 1;
    #1 chk("t6_flush_in_ready", 32'(bus.in_ready), 0);
    tick();
    bus.flush = 0;
    chk("t6_err_cleared", 32'(bus.timeout_err), 0);
    chk("t6_data_kept",   32'(bus.out_data), 32'h0FAA);

    // flush during WAIT_LD with a load present
    bus.in_valid = 1; bus.sel = 2'b01; bus.mem_data = 16'hAAAA;
    tick();
    bus.in_valid = 0; bus.flush = 1; bus.ld_valid = 1; bus.ld_res = 16'h5A5A;
    #1 chk("t7_ld_ack_flush", 32'(bus.ld_ack), 0);
    tick();
    bus.flush = 0;
    #1 chk("t7_out_valid", 32'(bus.out_valid), 0);
    chk("t7_in_ready", 32'(bus.in_ready), 1);
    bus.ld_valid = 0;

    // async reset in the middle of a wait
    bus.in_valid = 1; bus.sel = 2'b11; bus.mem_data = 16'h1357;
    tick();
    bus.in_valid = 0; bus.ld_valid = 1; bus.ld_res = 16'h2468;
    #1 chk("t8_ld_ack_pre", 32'(bus.ld_ack), 1);
    #1 reset_n = 1'b0;
    #1 chk("t8_rst_out_valid", 32'(bus.out_valid), 0);
    chk("t8_rst_out_data",  32'(bus.out_data), 0);
    chk("t8_rst_ld_sel",    32'(bus.out_ld_sel), 0);
    chk("t8_rst_ld_ack",    32'(bus.ld_ack), 0);
    chk("t8_rst_in_ready",  32'(bus.in_ready), 0);
    tick(); tick();
    reset_n = 1'b1;

    // post-reset sanity on the other lane
    bus.in_valid = 1; bus.sel = 2'b10; bus.mem_data = 16'h9876; bus.ld_valid = 1; bus.ld_res = 16'h5432;
    tick();
    bus.in_valid = 0; bus.ld_valid = 0;
    chk("t9_out_data",   32'(bus.out_data), 32'h5476);
    chk("t9_out_ld_sel", 32'(bus.out_ld_sel), 2'b10);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
